// File: rtl/ahb_line_refill_if.sv
// Cache-side miss/fill signals and AHB-Lite master signals of the I-cache line refill engine.
// The refill engine binds to `master`; the cache/memory side binds to `slave`.
interface ahb_line_refill_if;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic         fill_valid;
  logic [127:0] fill_line;
  logic [31:0]  fill_addr;
  logic         fill_error;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic [2:0]   hsize;
  logic         hwrite;
  logic         hready;
  logic [31:0]  hrdata;
  logic         hresp;

  modport master (
    input  req_valid, req_addr, hready, hrdata, hresp,
    output req_ready, crit_valid, crit_data, fill_valid, fill_line, fill_addr, fill_error,
           haddr, htrans, hburst, hsize, hwrite
  );

  modport slave (
    output req_valid, req_addr, hready, hrdata, hresp,
    input  req_ready, crit_valid, crit_data, fill_valid, fill_line, fill_addr, fill_error,
           haddr, htrans, hburst, hsize, hwrite
  );
endinterface

// File: rtl/ahb_line_refill.sv
// I-cache line refill: fetches one 128-bit line as an AHB-Lite WRAP4 read burst,
// returns the first (critical) beat early, then the whole line or an error.
module ahb_line_refill #(
  parameter bit CRIT_FIRST = 1'b1
) (
  input logic               hclk,
  input logic               hrst,
  ahb_line_refill_if.master bus
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned IDX_W  = 2;

  localparam logic [IDX_W-1:0] LAST_BEAT    = IDX_W'(BEATS - 1);
  localparam logic [1:0]       HTRANS_IDLE  = 2'b00;
  localparam logic [1:0]       HTRANS_NSEQ  = 2'b10;
  localparam logic [1:0]       HTRANS_SEQ   = 2'b11;
  localparam logic [2:0]       HBURST_WRAP4 = 3'b010;
  localparam logic [2:0]       HSIZE_WORD   = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR0 = 3'd1,
    ST_BURST = 3'd2,
    ST_LASTD = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e                           state_q, state_nxt;
  logic [IDX_W-1:0]                 ac_q, ac_nxt;
  logic [IDX_W-1:0]                 s_q, s_nxt;
  logic                             err_q, err_nxt;
  logic [ADDR_W-1:0]                base_q, base_nxt;

  logic                             cap_en;
  logic                             cap_crit;
  logic [IDX_W-1:0]                 cap_idx;

  logic [1:0]                       htrans_q, htrans_nxt;
  logic [ADDR_W-1:0]                haddr_q, haddr_nxt;
  logic                             req_ready_q, req_ready_nxt;
  logic                             crit_valid_q, crit_valid_nxt;
  logic                             fill_valid_q, fill_valid_nxt;
  logic                             fill_error_q, fill_error_nxt;
  logic [DATA_W-1:0]                crit_data_q;
  logic [BEATS-1:0][DATA_W-1:0]     line_q;

  // Byte-lane bits of the miss address never reach the bus; the line offset is taken separately.
  logic [3:0] unused_addr_bits;
  assign unused_addr_bits = bus.req_addr[3:0];

  // State register and burst bookkeeping.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q <= ST_IDLE;
      ac_q    <= '0;
      s_q     <= '0;
      err_q   <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_nxt;
      ac_q    <= ac_nxt;
      s_q     <= s_nxt;
      err_q   <= err_nxt;
      base_q  <= base_nxt;
    end
  end

  // Next-state and beat-capture decode.
  always_comb begin
    state_nxt = state_q;
    ac_nxt    = ac_q;
    s_nxt     = s_q;
    err_nxt   = err_q;
    base_nxt  = base_q;
    cap_en    = 1'b0;
    cap_crit  = 1'b0;
    cap_idx   = s_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          base_nxt  = {bus.req_addr[ADDR_W-1:4], 4'b0000};
          s_nxt     = CRIT_FIRST ? bus.req_addr[3:2] : IDX_W'(0);
          ac_nxt    = '0;
          err_nxt   = 1'b0;
          state_nxt = ST_ADDR0;
        end
      end
      ST_ADDR0: begin
        if (bus.hready) begin
          ac_nxt    = IDX_W'(1);
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        // First ERROR cycle drops the pending SEQ; a one-cycle ERROR ends the burst at once.
        if (bus.hresp) begin
          err_nxt   = 1'b1;
          state_nxt = bus.hready ? ST_DONE : ST_LASTD;
        end else if (bus.hready) begin
          cap_en   = 1'b1;
          cap_idx  = IDX_W'(s_q + ac_q - IDX_W'(1));
          cap_crit = (ac_q == IDX_W'(1));
          if (ac_q == LAST_BEAT) begin
            state_nxt = ST_LASTD;
          end else begin
            ac_nxt = IDX_W'(ac_q + IDX_W'(1));
          end
        end
      end
      ST_LASTD: begin
        if (bus.hready) begin
          state_nxt = ST_DONE;
          if (bus.hresp) begin
            err_nxt = 1'b1;
          end else if (!err_q) begin
            cap_en  = 1'b1;
            cap_idx = IDX_W'(s_q + LAST_BEAT);
          end
        end else if (bus.hresp) begin
          err_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state, so every bus and handshake output leaves a flop.
  always_comb begin
    htrans_nxt     = HTRANS_IDLE;
    haddr_nxt      = haddr_q;
    req_ready_nxt  = (state_nxt == ST_IDLE);
    fill_valid_nxt = (state_nxt == ST_DONE);
    fill_error_nxt = (state_nxt == ST_DONE) && err_nxt;
    crit_valid_nxt = cap_en && cap_crit;

    case (state_nxt)
      ST_ADDR0: begin
        htrans_nxt = HTRANS_NSEQ;
        haddr_nxt  = {base_nxt[ADDR_W-1:4], s_nxt, 2'b00};
      end
      ST_BURST: begin
        htrans_nxt = HTRANS_SEQ;
        haddr_nxt  = {base_nxt[ADDR_W-1:4], IDX_W'(s_nxt + ac_nxt), 2'b00};
      end
      default: begin
        htrans_nxt = HTRANS_IDLE;
      end
    endcase
  end

  // Output and line-buffer registers.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      htrans_q     <= HTRANS_IDLE;
      haddr_q      <= '0;
      req_ready_q  <= 1'b1;
      crit_valid_q <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_error_q <= 1'b0;
      crit_data_q  <= '0;
      line_q       <= '0;
    end else begin
      htrans_q     <= htrans_nxt;
      haddr_q      <= haddr_nxt;
      req_ready_q  <= req_ready_nxt;
      crit_valid_q <= crit_valid_nxt;
      fill_valid_q <= fill_valid_nxt;
      fill_error_q <= fill_error_nxt;
      if (cap_en) begin
        line_q[cap_idx] <= bus.hrdata;
      end
      if (cap_en && cap_crit) begin
        crit_data_q <= bus.hrdata;
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.crit_valid = crit_valid_q;
  assign bus.crit_data  = crit_data_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_error = fill_error_q;
  assign bus.fill_line  = line_q;
  assign bus.fill_addr  = base_q;
  assign bus.haddr      = haddr_q;
  assign bus.htrans     = htrans_q;
  assign bus.hburst     = HBURST_WRAP4;
  assign bus.hsize      = HSIZE_WORD;
  assign bus.hwrite     = 1'b0;

endmodule

// File: tb/tb_ahb_line_refill.sv
// Directed bench for ahb_line_refill: one critical-word-first and one line-base-first instance,
// each fed by a small AHB slave returning {salt, haddr[15:0]} for every accepted address.
module tb_ahb_line_refill;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic clk = 1'b0;
  logic hrst;

  ahb_line_refill_if if1 ();
  ahb_line_refill_if if0 ();

  ahb_line_refill #(.CRIT_FIRST(1'b1)) dut1 (.hclk(clk), .hrst(hrst), .bus(if1.master));
  ahb_line_refill #(.CRIT_FIRST(1'b0)) dut0 (.hclk(clk), .hrst(hrst), .bus(if0.master));

  always #5 clk = ~clk;

  // Slave models: data phase follows an address phase accepted with hready high.
  logic [15:0] salt1, salt0;
  logic        pend1, pend0;
  logic [31:0] paddr1, paddr0;

  always @(posedge clk) begin
    if (hrst) begin
      pend1 <= 1'b0;
      pend0 <= 1'b0;
    end else begin
      if (if1.hready) begin
        pend1  <= if1.htrans[1];
        paddr1 <= if1.haddr;
      end
      if (if0.hready) begin
        pend0  <= if0.htrans[1];
        paddr0 <= if0.haddr;
      end
    end
  end

  assign if1.hrdata = pend1 ? {salt1, paddr1[15:0]} : 32'h0BAD_0BAD;
  assign if0.hrdata = pend0 ? {salt0, paddr0[15:0]} : 32'h0BAD_0BAD;

  int crit_cnt1 = 0;
  int fill_cnt1 = 0;
  always @(posedge clk) begin
    if (if1.crit_valid) crit_cnt1 <= crit_cnt1 + 1;
    if (if1.fill_valid) fill_cnt1 <= fill_cnt1 + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] t1_addr [0:3] = '{32'h0000_1238, 32'h0000_123C, 32'h0000_1230, 32'h0000_1234};
  logic [31:0] t2_addr [0:3] = '{32'h0000_2000, 32'h0000_2004, 32'h0000_2008, 32'h0000_200C};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus1(input string tag, input logic [1:0] tr, input logic [31:0] ad);
    check({tag, "_htrans"}, 128'(if1.htrans), 128'(tr));
    if (tr != T_IDLE) check({tag, "_haddr"}, 128'(if1.haddr), 128'(ad));
  endtask

  task automatic fill1(input string tag, input logic err, input logic [127:0] line);
    check({tag, "_fill_valid"}, 128'(if1.fill_valid), 128'(1'b1));
    check({tag, "_fill_error"}, 128'(if1.fill_error), 128'(err));
    if (!err) begin
      check({tag, "_fill_line"}, if1.fill_line, line);
      check({tag, "_fill_addr"}, 128'(if1.fill_addr), 128'(32'h0000_1230));
    end
  endtask

  int base_crit;
  int base_fill;
  logic [1:0] exp_tr;
  int k;

  initial begin
    hrst = 1'b1;
    salt1 = 16'h0;
    salt0 = 16'h0;
    if1.req_valid = 1'b0; if1.req_addr = '0; if1.hready = 1'b1; if1.hresp = 1'b0;
    if0.req_valid = 1'b0; if0.req_addr = '0; if0.hready = 1'b1; if0.hresp = 1'b0;
    tick; tick;

    // Reset state
    check("rst_req_ready", 128'(if1.req_ready), 128'(1'b1));
    check("rst_htrans", 128'(if1.htrans), 128'(T_IDLE));
    check("rst_haddr", 128'(if1.haddr), 128'(32'h0));
    check("rst_crit_valid", 128'(if1.crit_valid), 128'(1'b0));
    check("rst_fill_valid", 128'(if1.fill_valid), 128'(1'b0));
    check("rst_fill_error", 128'(if1.fill_error), 128'(1'b0));
    check("rst_fill_line", if1.fill_line, 128'(0));
    check("rst_crit_data", 128'(if1.crit_data), 128'(32'h0));
    check("const_hburst", 128'(if1.hburst), 128'(3'b010));
    check("const_hsize", 128'(if1.hsize), 128'(3'b010));
    check("const_hwrite", 128'(if1.hwrite), 128'(1'b0));
    hrst = 1'b0;
    tick;

    // T1 (critical-first, 0x1238) and T2 (line-base-first, 0x200C) side by side, zero wait
    salt1 = 16'hA000; salt0 = 16'h5000;
    if1.req_valid = 1'b1; if1.req_addr = 32'h0000_1238;
    if0.req_valid = 1'b1; if0.req_addr = 32'h0000_200C;
    check("t1_c0_req_ready", 128'(if1.req_ready), 128'(1'b1));
    check("t1_c0_htrans", 128'(if1.htrans), 128'(T_IDLE));
    tick;
    if1.req_valid = 1'b0; if0.req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      exp_tr = (c == 1) ? T_NSEQ : T_SEQ;
      bus1($sformatf("t1_c%0d", c), exp_tr, t1_addr[c-1]);
      check($sformatf("t1_c%0d_req_ready", c), 128'(if1.req_ready), 128'(1'b0));
      check($sformatf("t1_c%0d_crit_valid", c), 128'(if1.crit_valid), 128'(c == 3));
      check($sformatf("t2_c%0d_htrans", c), 128'(if0.htrans), 128'(exp_tr));
      check($sformatf("t2_c%0d_haddr", c), 128'(if0.haddr), 128'(t2_addr[c-1]));
      check($sformatf("t2_c%0d_crit_valid", c), 128'(if0.crit_valid), 128'(c == 3));
      check($sformatf("t1_c%0d_hburst", c), 128'(if1.hburst), 128'(3'b010));
      if (c == 3) begin
        check("t1_crit_data", 128'(if1.crit_data), 128'(32'hA000_1238));
        check("t2_crit_data", 128'(if0.crit_data), 128'(32'h5000_2000));
      end
      tick;
    end
    bus1("t1_c5", T_IDLE, 32'h0);
    check("t2_c5_htrans", 128'(if0.htrans), 128'(T_IDLE));
    check("t1_c5_fill_valid", 128'(if1.fill_valid), 128'(1'b0));
    tick;
    fill1("t1_c6", 1'b0, {32'hA000_123C, 32'hA000_1238, 32'hA000_1234, 32'hA000_1230});
    check("t2_c6_fill_valid", 128'(if0.fill_valid), 128'(1'b1));
    check("t2_c6_fill_error", 128'(if0.fill_error), 128'(1'b0));
    check("t2_c6_fill_line", if0.fill_line,
          {32'h5000_200C, 32'h5000_2008, 32'h5000_2004, 32'h5000_2000});
    check("t2_c6_fill_addr", 128'(if0.fill_addr), 128'(32'h0000_2000));
    tick;
    check("t1_c7_fill_valid", 128'(if1.fill_valid), 128'(1'b0));
    check("t1_c7_req_ready", 128'(if1.req_ready), 128'(1'b1));
    tick;

    // T3: two wait states in the beat-1 data phase
    salt1 = 16'hB000;
    if1.req_valid = 1'b1; if1.req_addr = 32'h0000_1238;
    tick;
    if1.req_valid = 1'b0;
    bus1("t3_c1", T_NSEQ, 32'h0000_1238);
    tick;
    bus1("t3_c2", T_SEQ, 32'h0000_123C);
    tick;
    if1.hready = 1'b0;
    bus1("t3_c3", T_SEQ, 32'h0000_1230);
    check("t3_c3_crit_valid", 128'(if1.crit_valid), 128'(1'b1));
    check("t3_c3_crit_data", 128'(if1.crit_data), 128'(32'hB000_1238));
    tick;
    bus1("t3_c4", T_SEQ, 32'h0000_1230);
    check("t3_c4_crit_valid", 128'(if1.crit_valid), 128'(1'b0));
    tick;
    if1.hready = 1'b1;
    bus1("t3_c5", T_SEQ, 32'h0000_1230);
    tick;
    bus1("t3_c6", T_SEQ, 32'h0000_1234);
    tick;
    bus1("t3_c7", T_IDLE, 32'h0);
    check("t3_c7_fill_valid", 128'(if1.fill_valid), 128'(1'b0));
    tick;
    fill1("t3_c8", 1'b0, {32'hB000_123C, 32'hB000_1238, 32'hB000_1234, 32'hB000_1230});
    tick; tick;

    // T4: two-cycle ERROR response on beat 2
    salt1 = 16'hC000;
    base_crit = crit_cnt1;
    if1.req_valid = 1'b1; if1.req_addr = 32'h0000_1238;
    tick;
    if1.req_valid = 1'b0;
    bus1("t4_c1", T_NSEQ, 32'h0000_1238);
    tick;
    bus1("t4_c2", T_SEQ, 32'h0000_123C);
    tick;
    bus1("t4_c3", T_SEQ, 32'h0000_1230);
    tick;
    if1.hready = 1'b0; if1.hresp = 1'b1;
    bus1("t4_c4", T_SEQ, 32'h0000_1234);
    tick;
    if1.hready = 1'b1;
    bus1("t4_c5", T_IDLE, 32'h0);
    check("t4_c5_fill_valid", 128'(if1.fill_valid), 128'(1'b0));
    tick;
    if1.hresp = 1'b0;
    fill1("t4_c6", 1'b1, 128'(0));
    bus1("t4_c6", T_IDLE, 32'h0);
    tick;
    bus1("t4_c7", T_IDLE, 32'h0);
    check("t4_c7_fill_valid", 128'(if1.fill_valid), 128'(1'b0));
    check("t4_crit_pulses", 128'(crit_cnt1 - base_crit), 128'(1));
    check("t4_crit_data", 128'(if1.crit_data), 128'(32'hC000_1238));
    tick;

    // T5: reset during BURST, then a clean request
    salt1 = 16'hD000;
    base_fill = fill_cnt1;
    if1.req_valid = 1'b1; if1.req_addr = 32'h0000_1238;
    tick;
    if1.req_valid = 1'b0;
    bus1("t5_c1", T_NSEQ, 32'h0000_1238);
    tick;
    hrst = 1'b1;
    bus1("t5_c2", T_SEQ, 32'h0000_123C);
    tick;
    hrst = 1'b0;
    check("t5_c3_htrans", 128'(if1.htrans), 128'(T_IDLE));
    check("t5_c3_req_ready", 128'(if1.req_ready), 128'(1'b1));
    check("t5_c3_crit_valid", 128'(if1.crit_valid), 128'(1'b0));
    check("t5_c3_crit_data", 128'(if1.crit_data), 128'(32'h0));
    repeat (6) tick;
    check("t5_no_fill", 128'(fill_cnt1 - base_fill), 128'(0));
    check("t5_idle_htrans", 128'(if1.htrans), 128'(T_IDLE));

    salt1 = 16'hE000;
    if1.req_valid = 1'b1; if1.req_addr = 32'h0000_1234;
    tick;
    if1.req_valid = 1'b0;
    bus1("t5b_c1", T_NSEQ, 32'h0000_1234);
    tick;
    bus1("t5b_c2", T_SEQ, 32'h0000_1238);
    tick;
    bus1("t5b_c3", T_SEQ, 32'h0000_123C);
    check("t5b_c3_crit_data", 128'(if1.crit_data), 128'(32'hE000_1234));
    tick;
    bus1("t5b_c4", T_SEQ, 32'h0000_1230);
    tick;
    bus1("t5b_c5", T_IDLE, 32'h0);
    tick;
    fill1("t5b_c6", 1'b0, {32'hE000_123C, 32'hE000_1238, 32'hE000_1234, 32'hE000_1230});
    tick; tick;

    // T6: req_valid held high; second burst starts one idle-bus cycle after DONE
    salt1 = 16'hF000;
    base_fill = fill_cnt1;
    if1.req_valid = 1'b1; if1.req_addr = 32'h0000_1238;
    tick;
    for (int c = 1; c <= 13; c++) begin
      k = c % 7;
      exp_tr = (k == 1) ? T_NSEQ : ((k >= 2 && k <= 4) ? T_SEQ : T_IDLE);
      check($sformatf("t6_c%0d_req_ready", c), 128'(if1.req_ready), 128'(k == 0));
      check($sformatf("t6_c%0d_htrans", c), 128'(if1.htrans), 128'(exp_tr));
      if (k >= 1 && k <= 4) check($sformatf("t6_c%0d_haddr", c), 128'(if1.haddr), 128'(t1_addr[k-1]));
      check($sformatf("t6_c%0d_fill_valid", c), 128'(if1.fill_valid), 128'(k == 6));
      if (c == 13) check("t6_fill_line", if1.fill_line,
                         {32'hF000_123C, 32'hF000_1238, 32'hF000_1234, 32'hF000_1230});
      if (c == 8) if1.req_valid = 1'b0;
      tick;
    end
    check("t6_c14_req_ready", 128'(if1.req_ready), 128'(1'b1));
    check("t6_c14_htrans", 128'(if1.htrans), 128'(T_IDLE));
    check("t6_fill_count", 128'(fill_cnt1 - base_fill), 128'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
